dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter that shares the single data memory between the core's MEM stage (port C) and an external loader/debug master (port E). The core has priority. A starvation counter guarantees that port E is eventually granted, and the core is stalled for that one cycle. The block sits between the MEM-stage store/load lane logic and the data memory instance. Byte-lane masks and load extraction stay with the requesters.

## Interface
Parameters:
- MAX_WAIT, 8, maximum number of consecutive cycles port E may be blocked by the core before it is forcibly granted; legal range 1..255.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- c_req  in  1  core requests a memory access this cycle
- c_we  in  1  core access is a write
- c_wmask  in  4  core byte-write mask
- c_addr  in  32  core byte address
- c_wdata  in  32  core write data
- c_rdata  out  32  read data to core; combinational from mem_rdata
- c_stall  out  1  core access is not performed this cycle; the core holds the MEM stage
- e_valid  in  1  external request valid
- e_ready  out  1  external request accepted this cycle
- e_we, e_wmask, e_addr, e_wdata  in  1/4/32/32  external request fields; stable while e_valid && !e_ready
- e_rvalid  out  1  external read data valid
- e_rdata  out  32  external read data, registered
- e_rready  in  1  external master accepts read data
- mem_we  out  1  memory write enable
- mem_wmask  out  4  memory byte mask
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data; combinational from mem_addr

## Operation
- The FSM has two states, IDLE and RESP.
- grant_e = (state==IDLE) && e_valid && (!c_req || wait_cnt==MAX_WAIT) && !rst.
- e_ready = grant_e.
- c_stall = c_req && grant_e.
- Memory mux when grant_e: mem_we=e_we, mem_wmask=e_wmask, mem_addr=e_addr, mem_wdata=e_wdata.
- Memory mux otherwise: mem_we=c_req&&c_we&&!rst, and the remaining mem_* signals take the c_* fields.
- With no requester active, mem_addr follows c_addr and mem_we=0.
- c_rdata=mem_rdata at all times. It is meaningful only when c_req && !c_stall.
- In IDLE, a granted write completes at the same clock edge and the FSM stays in IDLE. No write response is issued.
- In IDLE, a granted read captures mem_rdata into e_rdata at the clock edge and moves to RESP.
- In RESP, e_rvalid=1 and e_ready=0. The core owns the memory unconditionally.
- In RESP, e_rready=1 returns the FSM to IDLE at the clock edge. e_rdata holds its value until the next read capture.
- wait_cnt runs only in IDLE. It increments, saturating at MAX_WAIT, in each cycle where e_valid && !grant_e.
- wait_cnt clears to 0 on a grant, or when e_valid=0. It holds its value in RESP.
- Counter width is 8 bits, with compare equality to MAX_WAIT.
- A write and a read in the same cycle cannot occur: exactly one port drives the memory each cycle.

## Timing
- Reset values: state=IDLE, wait_cnt=0, e_rvalid=0, e_rdata=0.
- While rst is high, e_ready=0, c_stall=0 and mem_we=0.
- Reset asserted mid-operation (RESP pending) drops e_rvalid immediately, and any pending read data is discarded.
- External read latency: handshake in cycle N, then e_rvalid=1 from cycle N+1 until the first cycle with e_rready=1, inclusive.
- Back-to-back external reads have a minimum spacing of 2 cycles: handshake, then RESP with e_rready=1, then the next handshake.
- External write latency: the memory is updated at the edge that ends the handshake cycle.
- Core access carries zero added latency when it is not stalled.
- Under continuous c_req and e_valid:
  - port E is granted in the cycle after wait_cnt reaches MAX_WAIT, i.e. the (MAX_WAIT+1)th cycle of blocking;
  - the core is stalled exactly 1 cycle per external access.
- If c_req drops in the same cycle that e_valid is raised, port E is granted that cycle with wait_cnt=0.

## Test plan
- Core only:
  - c_req=1, c_we=1, c_addr=0x10, c_wdata=0xDEADBEEF, c_wmask=4'b1111, then a read of 0x10 -> c_stall=0 throughout and c_rdata=0xDEADBEEF.
- External only:
  - e_valid write to 0x20 with data 0x12345678 -> e_ready=1 in the same cycle;
  - a subsequent read of 0x20 -> e_rvalid=1 next cycle with e_rdata=0x12345678;
  - e_rready held 0 for 3 cycles -> e_rvalid stays 1 and e_ready=0.
- Starvation with MAX_WAIT=8:
  - c_req held high, e_valid raised in cycle 0 -> e_ready=1 and c_stall=1 in cycle 8 only;
  - the core access in cycle 8 is not performed (its write is absent from memory);
  - the core's repeated request in cycle 9 completes.
- Byte-mask passthrough:
  - external write with e_wmask=4'b0100 and data 0xAABBCCDD to a word holding 0 -> word reads 0x00BB0000.
- Reset mid-RESP:
  - assert rst while e_rvalid=1 -> e_rvalid=0, e_rdata=0 and mem_we=0 immediately;
  - after release -> state IDLE and wait_cnt=0, and the first e_valid with c_req=0 is granted the same cycle.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the data-memory arbiter, its two requesters and the memory.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface dmem_arbiter_if;
   logic        c_req;
   logic        c_we;
   logic [3:0]  c_wmask;
   logic [31:0] c_addr;
   logic [31:0] c_wdata;
   logic [31:0] c_rdata;
   logic        c_stall;

   logic        e_valid;
   logic        e_ready;
   logic        e_we;
   logic [3:0]  e_wmask;
   logic [31:0] e_addr;
   logic [31:0] e_wdata;
   logic        e_rvalid;
   logic [31:0] e_rdata;
   logic        e_rready;

   logic        mem_we;
   logic [3:0]  mem_wmask;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   modport slave (
      input  c_req, c_we, c_wmask, c_addr, c_wdata,
      output c_rdata, c_stall,
      input  e_valid, e_we, e_wmask, e_addr, e_wdata, e_rready,
      output e_ready, e_rvalid, e_rdata,
      output mem_we, mem_wmask, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output c_req, c_we, c_wmask, c_addr, c_wdata,
      input  c_rdata, c_stall,
      output e_valid, e_we, e_wmask, e_addr, e_wdata, e_rready,
      input  e_ready, e_rvalid, e_rdata,
      input  mem_we, mem_wmask, mem_addr, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares one data memory between the core MEM stage (priority) and an external
// loader/debug master, with a starvation counter that forces an external grant.
//
// state | meaning
// IDLE  | memory free for arbitration; external writes complete here
// RESP  | external read data held on e_rdata until e_rready; core owns memory
module dmem_arbiter #(
   parameter int unsigned MAX_WAIT = 8
) (
   input logic           clk,
   input logic           rst,
   dmem_arbiter_if.slave bus
);

   typedef enum logic {IDLE, RESP} state_t;

   localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

   state_t      state, state_nx;
   logic [7:0]  wait_cnt, wait_cnt_nx;
   logic [31:0] e_rdata_q;
   logic        grant_e;
   logic        capture;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         wait_cnt  <= '0;
         e_rdata_q <= '0;
      end else begin
         state    <= state_nx;
         wait_cnt <= wait_cnt_nx;
         if (capture) e_rdata_q <= bus.mem_rdata;
      end
   end

   always_comb begin
      state_nx    = state;
      wait_cnt_nx = wait_cnt;
      capture     = 1'b0;
      grant_e     = (state == IDLE) && bus.e_valid
                    && (!bus.c_req || wait_cnt == MAX_WAIT_C) && !rst;
      case (state)
         IDLE: begin
            if (grant_e) begin
               wait_cnt_nx = '0;
               if (!bus.e_we) begin
                  state_nx = RESP;
                  capture  = 1'b1;
               end
            end else if (bus.e_valid) begin
               wait_cnt_nx = (wait_cnt == MAX_WAIT_C) ? wait_cnt : wait_cnt + 8'd1;
            end else begin
               wait_cnt_nx = '0;
            end
         end
         RESP: begin
            if (bus.e_rready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Exactly one port drives the memory; the core is the default owner.
   always_comb begin
      if (grant_e) begin
         bus.mem_we    = bus.e_we;
         bus.mem_wmask = bus.e_wmask;
         bus.mem_addr  = bus.e_addr;
         bus.mem_wdata = bus.e_wdata;
      end else begin
         bus.mem_we    = bus.c_req && bus.c_we && !rst;
         bus.mem_wmask = bus.c_wmask;
         bus.mem_addr  = bus.c_addr;
         bus.mem_wdata = bus.c_wdata;
      end
   end

   assign bus.e_ready  = grant_e;
   assign bus.c_stall  = bus.c_req && grant_e;
   assign bus.c_rdata  = bus.mem_rdata;
   assign bus.e_rvalid = (state == RESP);
   assign bus.e_rdata  = e_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: core/external access, starvation grant,
// byte masks and reset during a pending external read.
module tb_dmem_arbiter;
   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   logic [31:0] mem_model [0:63];

   dmem_arbiter_if bus ();

   dmem_arbiter #(.MAX_WAIT(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Byte-masked memory with combinational read, as the real instance behaves.
   assign bus.mem_rdata = mem_model[bus.mem_addr[7:2]];
   always @(posedge clk) begin
      if (bus.mem_we) begin
         for (int b = 0; b < 4; b++)
            if (bus.mem_wmask[b]) mem_model[bus.mem_addr[7:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.c_req = 0; bus.c_we = 0; bus.c_wmask = 4'hF; bus.c_addr = '0; bus.c_wdata = '0;
      bus.e_valid = 0; bus.e_we = 0; bus.e_wmask = 4'hF; bus.e_addr = '0; bus.e_wdata = '0;
      bus.e_rready = 0;
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem_model[i] = '0;
      idle_inputs();
      rst = 1;
      bus.e_valid = 1;
      bus.c_req = 1; bus.c_we = 1;
      #2;
      chk("rst_e_ready", bus.e_ready, 0);
      chk("rst_c_stall", bus.c_stall, 0);
      chk("rst_mem_we", bus.mem_we, 0);
      chk("rst_e_rvalid", bus.e_rvalid, 0);
      chk("rst_e_rdata", bus.e_rdata, 0);
      step();
      step();
      rst = 0;
      idle_inputs();

      // Core write then read
      bus.c_req = 1; bus.c_we = 1; bus.c_addr = 32'h10; bus.c_wdata = 32'hDEADBEEF;
      #1;
      chk("core_wr_stall", bus.c_stall, 0);
      chk("core_wr_mem_we", bus.mem_we, 1);
      step();
      bus.c_we = 0;
      #1;
      chk("core_rd_stall", bus.c_stall, 0);
      chk("core_rd_data", bus.c_rdata, 32'hDEADBEEF);
      step();
      idle_inputs();

      // External write, then read with a held response
      bus.e_valid = 1; bus.e_we = 1; bus.e_addr = 32'h20; bus.e_wdata = 32'h12345678;
      #1;
      chk("ext_wr_ready", bus.e_ready, 1);
      chk("ext_wr_mem_addr", bus.mem_addr, 32'h20);
      chk("ext_wr_mem_we", bus.mem_we, 1);
      step();
      bus.e_we = 0;
      #1;
      chk("ext_rd_ready", bus.e_ready, 1);
      chk("ext_rd_rvalid_n", bus.e_rvalid, 0);
      step();
      bus.e_valid = 0;
      #1;
      chk("ext_rd_rvalid", bus.e_rvalid, 1);
      chk("ext_rd_data", bus.e_rdata, 32'h12345678);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("ext_hold_rvalid", bus.e_rvalid, 1);
         chk("ext_hold_ready", bus.e_ready, 0);
      end
      bus.e_rready = 1;
      #1;
      chk("ext_rready_rvalid", bus.e_rvalid, 1);
      step();
      bus.e_rready = 0;
      #1;
      chk("ext_done_rvalid", bus.e_rvalid, 0);
      chk("ext_done_rdata_held", bus.e_rdata, 32'h12345678);
      idle_inputs();

      // Starvation: core always requests, external write waits for the forced grant
      bus.e_valid = 1; bus.e_we = 1; bus.e_addr = 32'h40; bus.e_wdata = 32'h55;
      bus.c_req = 1; bus.c_we = 1;
      for (int i = 0; i <= 8; i++) begin
         bus.c_addr  = (i == 8) ? 32'h34 : 32'h30;
         bus.c_wdata = (i == 8) ? 32'h0BAD : 32'(i);
         #1;
         chk($sformatf("starve_stall_c%0d", i), bus.c_stall, (i == 8) ? 1 : 0);
         chk($sformatf("starve_ready_c%0d", i), bus.e_ready, (i == 8) ? 1 : 0);
         step();
      end
      bus.e_valid = 0;
      #1;
      chk("starve_core_skipped", mem_model[13], 0);
      chk("starve_retry_stall", bus.c_stall, 0);
      step();
      chk("starve_retry_done", mem_model[13], 32'h0BAD);
      chk("starve_ext_written", mem_model[16], 32'h55);
      chk("starve_core_last", mem_model[12], 32'h7);
      idle_inputs();

      // Byte-mask passthrough
      bus.e_valid = 1; bus.e_we = 1; bus.e_wmask = 4'b0100; bus.e_addr = 32'h50;
      bus.e_wdata = 32'hAABBCCDD;
      #1;
      chk("mask_ready", bus.e_ready, 1);
      step();
      idle_inputs();
      bus.c_req = 1; bus.c_addr = 32'h50;
      #1;
      chk("mask_word", bus.c_rdata, 32'h00BB0000);
      step();
      idle_inputs();

      // Reset while a read response is pending
      bus.e_valid = 1; bus.e_addr = 32'h20;
      step();
      bus.e_valid = 0;
      bus.c_req = 1; bus.c_we = 1; bus.c_addr = 32'h60; bus.c_wdata = 32'hFFFFFFFF;
      #1;
      chk("rr_rvalid_before", bus.e_rvalid, 1);
      rst = 1;
      #1;
      chk("rr_rvalid", bus.e_rvalid, 0);
      chk("rr_rdata", bus.e_rdata, 0);
      chk("rr_mem_we", bus.mem_we, 0);
      step();
      rst = 0;
      chk("rr_no_core_write", mem_model[24], 0);
      idle_inputs();
      bus.e_valid = 1; bus.e_addr = 32'h10;
      #1;
      chk("rr_first_grant", bus.e_ready, 1);
      step();
      bus.e_valid = 0; bus.e_rready = 1;
      #1;
      chk("rr_read_rvalid", bus.e_rvalid, 1);
      chk("rr_read_data", bus.e_rdata, 32'hDEADBEEF);
      step();
      chk("rr_read_done", bus.e_rvalid, 0);
      idle_inputs();

      // Counter restarts from zero after reset: forced grant again on cycle 8
      bus.e_valid = 1; bus.e_we = 1; bus.e_addr = 32'h44; bus.c_req = 1; bus.c_addr = 32'h48;
      for (int i = 0; i <= 8; i++) begin
         #1;
         chk($sformatf("restarve_ready_c%0d", i), bus.e_ready, (i == 8) ? 1 : 0);
         step();
      end
      idle_inputs();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
